// File: rtl/axi4_ram_wo_reset.sv
// AXI4 slave RAM with independent write and read burst engines.
// Only handshake/control state is reset; mem[] keeps its contents across rst so it can be preloaded.
module axi4_ram_wo_reset #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int ID_WIDTH        = 8,
    parameter int PIPELINE_OUTPUT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ID_WIDTH-1:0]        s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]      s_axi_awaddr,
    input  logic [7:0]                 s_axi_awlen,
    input  logic [2:0]                 s_axi_awsize,
    input  logic [1:0]                 s_axi_awburst,
    input  logic                       s_axi_awlock,
    input  logic [3:0]                 s_axi_awcache,
    input  logic [2:0]                 s_axi_awprot,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [DATA_WIDTH-1:0]      s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]    s_axi_wstrb,
    input  logic                       s_axi_wlast,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    output logic [ID_WIDTH-1:0]        s_axi_bid,
    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    input  logic [ID_WIDTH-1:0]        s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]      s_axi_araddr,
    input  logic [7:0]                 s_axi_arlen,
    input  logic [2:0]                 s_axi_arsize,
    input  logic [1:0]                 s_axi_arburst,
    input  logic                       s_axi_arlock,
    input  logic [3:0]                 s_axi_arcache,
    input  logic [2:0]                 s_axi_arprot,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    output logic [ID_WIDTH-1:0]        s_axi_rid,
    output logic [DATA_WIDTH-1:0]      s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rlast,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready
);

    localparam int STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int WORD_LSB    = $clog2(STRB_WIDTH);
    localparam int INDEX_WIDTH = ADDR_WIDTH - WORD_LSB;
    localparam int DEPTH       = 2 ** INDEX_WIDTH;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // WRAP bursts deliberately step like INCR; FIXED keeps the same address.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else begin
            next_addr = addr + (ADDR_ONE << size);
        end
    endfunction

    // ------------------------------------------------------------------ write channel
    state_t                  wr_state_r, wr_state_s;
    logic [ID_WIDTH-1:0]     wr_id_r;
    logic [ADDR_WIDTH-1:0]   wr_addr_r;
    logic [7:0]              wr_cnt_r;
    logic [2:0]              wr_size_r;
    logic [1:0]              wr_burst_r;
    logic                    awready_r, wready_r, bvalid_r, bvalid_s;
    logic [ID_WIDTH-1:0]     bid_r;
    logic                    aw_fire_s, w_fire_s, w_last_s;
    logic [INDEX_WIDTH-1:0]  wr_index_s;

    assign aw_fire_s  = s_axi_awvalid && awready_r;
    assign w_fire_s   = s_axi_wvalid && wready_r;
    assign w_last_s   = w_fire_s && (wr_cnt_r == 8'd0);
    assign wr_index_s = wr_addr_r[ADDR_WIDTH-1:WORD_LSB];

    // Write FSM next state and B-valid next value.
    always_comb begin
        wr_state_s = wr_state_r;
        bvalid_s   = bvalid_r;
        case (wr_state_r)
            ST_IDLE: begin
                if (aw_fire_s) begin
                    wr_state_s = ST_BURST;
                end else begin
                    wr_state_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (w_last_s) begin
                    wr_state_s = ST_IDLE;
                end else begin
                    wr_state_s = ST_BURST;
                end
            end
            default: wr_state_s = ST_IDLE;
        endcase
        if (w_last_s) begin
            bvalid_s = 1'b1;
        end else if (s_axi_bready) begin
            bvalid_s = 1'b0;
        end else begin
            bvalid_s = bvalid_r;
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_r <= ST_IDLE;
        end else begin
            wr_state_r <= wr_state_s;
        end
    end

    // Write burst bookkeeping and AW/W/B handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bid_r      <= '0;
            wr_id_r    <= '0;
            wr_addr_r  <= '0;
            wr_cnt_r   <= 8'd0;
            wr_size_r  <= 3'd0;
            wr_burst_r <= 2'd0;
        end else begin
            awready_r <= (wr_state_s == ST_IDLE) && !bvalid_s;
            bvalid_r  <= bvalid_s;
            if (aw_fire_s) begin
                wr_id_r    <= s_axi_awid;
                wr_addr_r  <= s_axi_awaddr;
                wr_cnt_r   <= s_axi_awlen;
                wr_size_r  <= s_axi_awsize;
                wr_burst_r <= s_axi_awburst;
                wready_r   <= 1'b1;
            end else if (w_fire_s) begin
                wr_addr_r <= next_addr(wr_addr_r, wr_size_r, wr_burst_r);
                wr_cnt_r  <= wr_cnt_r - 8'd1;
                if (w_last_s) begin
                    wready_r <= 1'b0;
                    bid_r    <= wr_id_r;
                end
            end
        end
    end

    // Byte-lane writes into the array; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (!rst && w_fire_s) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_axi_wstrb[i]) begin
                    mem[wr_index_s][8*i +: 8] <= s_axi_wdata[8*i +: 8];
                end
            end
        end
    end

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = wready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bid     = bid_r;
    assign s_axi_bresp   = 2'b00;

    // ------------------------------------------------------------------ read channel
    state_t                  rd_state_r, rd_state_s;
    logic [ID_WIDTH-1:0]     rd_id_r;
    logic [ADDR_WIDTH-1:0]   rd_addr_r, rd_addr_s;
    logic [7:0]              rd_cnt_r;
    logic [2:0]              rd_size_r;
    logic [1:0]              rd_burst_r;
    logic                    arready_r;
    logic                    core_valid_r, core_valid_s, core_last_r;
    logic [DATA_WIDTH-1:0]   core_data_r;
    logic [ID_WIDTH-1:0]     core_id_r;
    logic                    core_ready_s, ar_fire_s, core_fire_s, core_done_s, core_load_s;

    assign ar_fire_s   = s_axi_arvalid && arready_r;
    assign core_fire_s = core_valid_r && core_ready_s;
    assign core_done_s = core_fire_s && core_last_r;
    assign core_load_s = ar_fire_s || (core_fire_s && !core_last_r);

    // Read FSM next state, next beat address and core-stage valid.
    always_comb begin
        rd_state_s   = rd_state_r;
        rd_addr_s    = rd_addr_r;
        core_valid_s = core_valid_r;
        case (rd_state_r)
            ST_IDLE: begin
                if (ar_fire_s) begin
                    rd_state_s = ST_BURST;
                end else begin
                    rd_state_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (core_done_s) begin
                    rd_state_s = ST_IDLE;
                end else begin
                    rd_state_s = ST_BURST;
                end
            end
            default: rd_state_s = ST_IDLE;
        endcase
        if (ar_fire_s) begin
            rd_addr_s = s_axi_araddr;
        end else begin
            rd_addr_s = next_addr(rd_addr_r, rd_size_r, rd_burst_r);
        end
        if (core_load_s) begin
            core_valid_s = 1'b1;
        end else if (core_fire_s) begin
            core_valid_s = 1'b0;
        end else begin
            core_valid_s = core_valid_r;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_r <= ST_IDLE;
        end else begin
            rd_state_r <= rd_state_s;
        end
    end

    // Read burst bookkeeping; the core stage holds its beat until it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            arready_r    <= 1'b0;
            core_valid_r <= 1'b0;
            core_last_r  <= 1'b0;
            core_data_r  <= '0;
            core_id_r    <= '0;
            rd_id_r      <= '0;
            rd_addr_r    <= '0;
            rd_cnt_r     <= 8'd0;
            rd_size_r    <= 3'd0;
            rd_burst_r   <= 2'd0;
        end else begin
            arready_r    <= (rd_state_s == ST_IDLE) && !core_valid_s;
            core_valid_r <= core_valid_s;
            if (ar_fire_s) begin
                rd_id_r    <= s_axi_arid;
                rd_cnt_r   <= s_axi_arlen;
                rd_size_r  <= s_axi_arsize;
                rd_burst_r <= s_axi_arburst;
            end else if (core_fire_s) begin
                rd_cnt_r <= rd_cnt_r - 8'd1;
            end
            if (core_load_s) begin
                rd_addr_r   <= rd_addr_s;
                core_data_r <= mem[rd_addr_s[ADDR_WIDTH-1:WORD_LSB]];
                core_id_r   <= ar_fire_s ? s_axi_arid : rd_id_r;
                core_last_r <= ar_fire_s ? (s_axi_arlen == 8'd0) : (rd_cnt_r == 8'd1);
            end else if (core_done_s) begin
                core_last_r <= 1'b0;
            end
        end
    end

    generate
        if (PIPELINE_OUTPUT != 0) begin : g_out_reg
            logic                  out_valid_r, out_last_r;
            logic [DATA_WIDTH-1:0] out_data_r;
            logic [ID_WIDTH-1:0]   out_id_r;

            assign core_ready_s = !out_valid_r || s_axi_rready;

            // Output register refills only when empty or its beat is being taken.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    out_data_r  <= '0;
                    out_id_r    <= '0;
                end else if (core_ready_s) begin
                    out_valid_r <= core_valid_r;
                    out_last_r  <= core_last_r;
                    out_data_r  <= core_data_r;
                    out_id_r    <= core_id_r;
                end
            end

            assign s_axi_rvalid = out_valid_r;
            assign s_axi_rlast  = out_last_r;
            assign s_axi_rdata  = out_data_r;
            assign s_axi_rid    = out_id_r;
        end else begin : g_out_direct
            assign core_ready_s = s_axi_rready;
            assign s_axi_rvalid = core_valid_r;
            assign s_axi_rlast  = core_last_r;
            assign s_axi_rdata  = core_data_r;
            assign s_axi_rid    = core_id_r;
        end
    endgenerate

    assign s_axi_arready = arready_r;
    assign s_axi_rresp   = 2'b00;

    logic unused_s;
    assign unused_s = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_wlast,
                        s_axi_arlock, s_axi_arcache, s_axi_arprot};

endmodule

// File: tb/tb_axi4_ram_wo_reset.sv
// Randomized bench for axi4_ram_wo_reset: bursts are checked against a word-array reference
// whose beat addresses are computed in closed form from start address, beat number, size and burst type.
module tb_axi4_ram_wo_reset;
    localparam int DEPTH = 16384;
    localparam int BOUND = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_axi_awid = 8'd0;
    logic [15:0] s_axi_awaddr = 16'd0;
    logic [7:0]  s_axi_awlen = 8'd0;
    logic [2:0]  s_axi_awsize = 3'd0;
    logic [1:0]  s_axi_awburst = 2'd0;
    logic        s_axi_awlock = 1'b0;
    logic [3:0]  s_axi_awcache = 4'd0;
    logic [2:0]  s_axi_awprot = 3'd0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = 32'd0;
    logic [3:0]  s_axi_wstrb = 4'd0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [7:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [7:0]  s_axi_arid = 8'd0;
    logic [15:0] s_axi_araddr = 16'd0;
    logic [7:0]  s_axi_arlen = 8'd0;
    logic [2:0]  s_axi_arsize = 3'd0;
    logic [1:0]  s_axi_arburst = 2'd0;
    logic        s_axi_arlock = 1'b0;
    logic [3:0]  s_axi_arcache = 4'd0;
    logic [2:0]  s_axi_arprot = 3'd0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [7:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;

    always #5 clk = ~clk;

    axi4_ram_wo_reset dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    int          total_cnt = 0;
    int          bad_cnt = 0;
    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] w_data [0:255];
    logic [3:0]  w_strb [0:255];
    logic [31:0] r_got [0:255];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pre_val(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    function automatic logic [15:0] beat_addr(input logic [15:0] start, input int b,
                                              input logic [2:0] size, input logic [1:0] burst);
        int step;
        step = (burst == 2'b00) ? 0 : (1 << size);
        return 16'(int'(start) + b * step);
    endfunction

    task automatic fill_random(input int len);
        for (int i = 0; i <= len; i++) begin
            w_data[i] = $urandom;
            w_strb[i] = 4'($urandom_range(0, 15));
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [7:0] id, input int nsend);
        int cyc;
        int b;
        int stall;
        int idx;
        logic [15:0] a;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        cyc = 0;
        while (!s_axi_awready && cyc < BOUND) begin
            @(negedge clk); cyc++;
        end
        check_val("aw_handshake", 64'(cyc < BOUND), 64'd1);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        check_val("wready_after_aw", 64'(s_axi_wready), 64'd1);
        b = 0; cyc = 0;
        while (b < nsend && cyc < BOUND) begin
            s_axi_wvalid = ($urandom_range(0, 3) != 0);
            s_axi_wdata  = w_data[b];
            s_axi_wstrb  = w_strb[b];
            s_axi_wlast  = (b == int'(len));
            if (s_axi_wvalid && s_axi_wready) begin
                a = beat_addr(addr, b, size, burst);
                idx = int'(a >> 2);
                for (int i = 0; i < 4; i++) begin
                    if (w_strb[b][i]) ref_mem[idx][8*i +: 8] = w_data[b][8*i +: 8];
                end
                b++;
            end
            @(negedge clk); cyc++;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        check_val("w_beats", 64'(b), 64'(nsend));
        if (nsend == int'(len) + 1) begin
            check_val("wready_done", 64'(s_axi_wready), 64'd0);
            stall = $urandom_range(0, 5);
            for (int s = 0; s < stall; s++) begin
                check_val("bvalid_hold", 64'(s_axi_bvalid), 64'd1);
                check_val("awready_stall", 64'(s_axi_awready), 64'd0);
                check_val("bid_hold", 64'(s_axi_bid), 64'(id));
                @(negedge clk);
            end
            s_axi_bready = 1'b1;
            check_val("bvalid", 64'(s_axi_bvalid), 64'd1);
            check_val("bid", 64'(s_axi_bid), 64'(id));
            check_val("bresp", 64'(s_axi_bresp), 64'd0);
            @(negedge clk);
            s_axi_bready = 1'b0;
            check_val("bvalid_clear", 64'(s_axi_bvalid), 64'd0);
            check_val("awready_back", 64'(s_axi_awready), 64'd1);
        end
    endtask

    // Called at a negedge; returns at a negedge. Received beats land in r_got[].
    task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [7:0] id, input int nrecv);
        int cyc;
        int b;
        logic [15:0] a;
        logic [31:0] exp_word;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        cyc = 0;
        while (!s_axi_arready && cyc < BOUND) begin
            @(negedge clk); cyc++;
        end
        check_val("ar_handshake", 64'(cyc < BOUND), 64'd1);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        b = 0; cyc = 0;
        while (b < nrecv && cyc < BOUND) begin
            s_axi_rready = ($urandom_range(0, 2) != 0);
            a = beat_addr(addr, b, size, burst);
            exp_word = ref_mem[int'(a >> 2)];
            check_val("rvalid", 64'(s_axi_rvalid), 64'd1);
            check_val("rdata", 64'(s_axi_rdata), 64'(exp_word));
            check_val("rid", 64'(s_axi_rid), 64'(id));
            check_val("rlast", 64'(s_axi_rlast), 64'(b == int'(len)));
            check_val("rresp", 64'(s_axi_rresp), 64'd0);
            if (s_axi_rvalid && s_axi_rready) begin
                r_got[b] = s_axi_rdata;
                b++;
            end
            @(negedge clk); cyc++;
        end
        s_axi_rready = 1'b0;
        check_val("r_beats", 64'(b), 64'(nrecv));
        if (nrecv == int'(len) + 1) begin
            check_val("rvalid_done", 64'(s_axi_rvalid), 64'd0);
            check_val("arready_back", 64'(s_axi_arready), 64'd1);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_awready"}, 64'(s_axi_awready), 64'd0);
        check_val({tag, "_wready"}, 64'(s_axi_wready), 64'd0);
        check_val({tag, "_bvalid"}, 64'(s_axi_bvalid), 64'd0);
        check_val({tag, "_arready"}, 64'(s_axi_arready), 64'd0);
        check_val({tag, "_rvalid"}, 64'(s_axi_rvalid), 64'd0);
        check_val({tag, "_rlast"}, 64'(s_axi_rlast), 64'd0);
        check_val({tag, "_rdata"}, 64'(s_axi_rdata), 64'd0);
        check_val({tag, "_rid"}, 64'(s_axi_rid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        for (int i = 0; i < DEPTH; i++) begin
            dut.mem[i] <= pre_val(i);
            ref_mem[i] = pre_val(i);
        end
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // single word write/read
        w_data[0] = 32'hDEADBEEF; w_strb[0] = 4'hF;
        do_write(16'h0010, 8'd0, 3'd2, 2'b01, 8'h3C, 1);
        do_read(16'h0010, 8'd0, 3'd2, 2'b01, 8'h5A, 1);
        check_val("single_word", 64'(r_got[0]), 64'h0000_0000_DEAD_BEEF);

        // byte strobe merge
        w_data[0] = 32'h11223344; w_strb[0] = 4'hF;
        do_write(16'h0020, 8'd0, 3'd2, 2'b01, 8'h01, 1);
        w_data[0] = 32'h0000AA00; w_strb[0] = 4'b0010;
        do_write(16'h0020, 8'd0, 3'd2, 2'b01, 8'h02, 1);
        do_read(16'h0020, 8'd0, 3'd2, 2'b01, 8'h03, 1);
        check_val("byte_strobe", 64'(r_got[0]), 64'h0000_0000_1122_AA44);

        // INCR burst of four
        for (int i = 0; i < 4; i++) begin
            w_data[i] = 32'(i + 1); w_strb[i] = 4'hF;
        end
        do_write(16'h0100, 8'd3, 3'd2, 2'b01, 8'h77, 4);
        do_read(16'h0100, 8'd3, 3'd2, 2'b01, 8'h99, 4);
        for (int i = 0; i < 4; i++) check_val("incr_burst", 64'(r_got[i]), 64'(i + 1));

        // FIXED burst: last beat wins, next word untouched
        w_data[0] = 32'hAAAA0001; w_data[1] = 32'hBBBB0002; w_data[2] = 32'hCCCC0003;
        for (int i = 0; i < 3; i++) w_strb[i] = 4'hF;
        do_write(16'h0040, 8'd2, 3'd2, 2'b00, 8'h10, 3);
        do_read(16'h0040, 8'd0, 3'd2, 2'b01, 8'h11, 1);
        check_val("fixed_last", 64'(r_got[0]), 64'h0000_0000_CCCC_0003);
        do_read(16'h0044, 8'd0, 3'd2, 2'b01, 8'h12, 1);
        check_val("fixed_neighbour", 64'(r_got[0]), 64'(pre_val(17)));

        // burst running off the top of the address space wraps to index 0
        fill_random(3);
        do_write(16'hFFF8, 8'd3, 3'd2, 2'b01, 8'h20, 4);
        do_read(16'hFFF8, 8'd3, 3'd2, 2'b10, 8'h21, 4);

        // randomized bursts
        for (int t = 0; t < 40; t++) begin
            addr  = 16'($urandom_range(0, 65535));
            len   = 8'($urandom_range(0, 15));
            size  = 3'($urandom_range(0, 2));
            burst = 2'($urandom_range(0, 2));
            fill_random(int'(len));
            do_write(addr, len, size, burst, 8'($urandom), int'(len) + 1);
            if (t % 2 == 0) begin
                do_read(addr, len, size, burst, 8'($urandom), int'(len) + 1);
            end else begin
                len = 8'($urandom_range(0, 15));
                do_read(16'($urandom_range(0, 65535)), len, 3'($urandom_range(0, 2)),
                        2'($urandom_range(0, 2)), 8'($urandom), int'(len) + 1);
            end
        end

        // reset in the middle of a write burst
        for (int i = 0; i < 4; i++) begin
            w_data[i] = 32'hF00D0000 + 32'(i); w_strb[i] = 4'hF;
        end
        do_write(16'h0200, 8'd3, 3'd2, 2'b01, 8'h44, 2);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("wr_abort");
        rst = 1'b0;
        @(negedge clk);
        do_read(16'h0200, 8'd3, 3'd2, 2'b01, 8'h45, 4);
        check_val("abort_kept", 64'(r_got[1]), 64'h0000_0000_F00D_0001);
        check_val("abort_unwritten", 64'(r_got[2]), 64'(pre_val(130)));

        // reset in the middle of a read burst
        do_read(16'h0300, 8'd7, 3'd2, 2'b01, 8'h46, 2);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("rd_abort");

        // preload through the hierarchy while in reset
        dut.mem[5] <= 32'hCAFEF00D;
        ref_mem[5] = 32'hCAFEF00D;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_read(16'h0014, 8'd0, 3'd2, 2'b01, 8'h47, 1);
        check_val("preload", 64'(r_got[0]), 64'h0000_0000_CAFE_F00D);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
